// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
// The master issues operations; the slave (the adder) returns results and status.
interface serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             zero;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, zero, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, zero, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, registered carry between digits.
// Optional zero/overflow flags are built when SERIAL_ADDER_FLAGS_EN is defined.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic          clk,
  input  logic          reset,
  serial_adder_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  // One digit of the chain: DIGIT full-adder stages rippling combinationally.
  function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic c);
    logic [DIGIT:0] r;
    logic           k;
    r = '0;
    k = c;
    for (int i = 0; i < DIGIT; i++) begin
      r[i] = x[i] ^ y[i] ^ k;
      k    = (x[i] & y[i]) | (k & (x[i] ^ y[i]));
    end
    r[DIGIT] = k;
    return r;
  endfunction

  logic [DIGIT:0]         dsum;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       next_res;
  logic [WIDTH-1:0]       b_eff;

  assign dsum     = digit_add(a_sr[DIGIT-1:0], b_sr[DIGIT-1:0], carry);
  assign res_cat  = {dsum[DIGIT-1:0], res_sr};
  assign next_res = res_cat[WIDTH+DIGIT-1:DIGIT];
  assign b_eff    = bus.sub ? ~bus.b : bus.b;

`ifdef SERIAL_ADDER_FLAGS_EN
  logic msb_a;
  logic msb_b;
  logic zero_r;
  logic ovf_r;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
`ifdef SERIAL_ADDER_FLAGS_EN
      msb_a  <= 1'b0;
      msb_b  <= 1'b0;
      zero_r <= 1'b0;
      ovf_r  <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= b_eff;
            res_sr <= '0;
            carry  <= bus.sub ? 1'b1 : bus.cin;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
`ifdef SERIAL_ADDER_FLAGS_EN
            msb_a  <= bus.a[WIDTH-1];
            msb_b  <= b_eff[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= next_res;
          carry  <= dsum[DIGIT];
          cnt    <= cnt + 1'b1;
          // Last digit: publish straight from the combinational slice.
          if (cnt == LAST) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            sum_r  <= next_res;
            cout_r <= dsum[DIGIT];
`ifdef SERIAL_ADDER_FLAGS_EN
            zero_r <= (next_res == '0);
            ovf_r  <= (msb_a == msb_b) && (next_res[WIDTH-1] != msb_a);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
`ifdef SERIAL_ADDER_FLAGS_EN
  assign bus.zero = zero_r;
  assign bus.ovf  = ovf_r;
`else
  assign bus.zero = 1'b0;
  assign bus.ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes expected results, a monitor
// pops and compares each done pulse (sum, cout, flags, latency, busy length).
module tb_serial_adder #(
  parameter int DIGIT = 1
);
  localparam int WIDTH = 16;
  localparam int N     = WIDTH / DIGIT;
`ifdef SERIAL_ADDER_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        zero;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        zero;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   busy_cnt   = 0;
  exp_t e;

  // zero/ovf columns are the flags-build values; they are masked to 0 otherwise.
  vec_t vecs[8] = '{
    '{16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0},
    '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1},
    '{16'h7FFF, 16'h0001, 1'b1, 1'b0, 16'h8001, 1'b0, 1'b0, 1'b1},
    '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0},
    '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0},
    '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1},
    '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0}
  };

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared = compared + 1;
    if (act !== req) begin
      mismatched = mismatched + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [15:0] s, input logic co, input logic z, input logic o);
    exp_t x;
    x.sum  = s;
    x.cout = co;
    x.zero = FLAGS ? z : 1'b0;
    x.ovf  = FLAGS ? o : 1'b0;
    x.acc  = cyc;
    q.push_back(x);
  endtask

  // Drive one operation; the accepting edge is the posedge after the drive.
  task automatic issue(input vec_t v, input bit push);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = v.a;
    bus.b     = v.b;
    bus.cin   = v.cin;
    bus.sub   = v.sub;
    @(posedge clk);
    #1;
    if (push) push_exp(v.sum, v.cout, v.zero, v.ovf);
    bus.start = 1'b0;
    bus.a     = 16'hDEAD;
    bus.b     = 16'hBEEF;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k = k + 1;
    end while (!bus.done && k < 200);
    if (!bus.done) begin
      compared   = compared + 1;
      mismatched = mismatched + 1;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, k);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt = busy_cnt + 1;
      if (bus.done) begin
        if (q.size() == 0) begin
          compared   = compared + 1;
          mismatched = mismatched + 1;
          $display("FAIL unexpected_done: sum=0x%0h with no pending operation", bus.sum);
        end else begin
          e = q.pop_front();
          chk("sum",          32'(bus.sum),            32'(e.sum));
          chk("cout",         32'(bus.cout),           32'(e.cout));
          chk("zero",         32'(bus.zero),           32'(e.zero));
          chk("ovf",          32'(bus.ovf),            32'(e.ovf));
          chk("latency",      32'(cyc - e.acc + 1),    32'(N + 1));
          chk("busy_cycles",  32'(busy_cnt),           32'(N));
          chk("busy_at_done", 32'(bus.busy),           32'd0);
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum",  32'(bus.sum),  32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd0);
    chk("rst_ovf",  32'(bus.ovf),  32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i], 1'b1);
      wait_done("vec");
    end

    // start pulsed mid-run with different operands must not disturb the result
    issue('{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0}, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    bus.b     = 16'hFFFF;
    bus.sub   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    wait_done("run_start_ignored");

    // asynchronous reset mid-operation discards the partial result
    issue('{16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0}, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_done", 32'(bus.done), 32'd0);
    chk("async_rst_sum",  32'(bus.sum),  32'd0);
    chk("async_rst_cout", 32'(bus.cout), 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    issue('{16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0}, 1'b1);
    wait_done("after_reset");

    // back-to-back: start held through DONE, operands changed in the DONE cycle
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h0001;
    bus.b     = 16'h0001;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    @(posedge clk);
    #1;
    push_exp(16'h0002, 1'b0, 1'b0, 1'b0);
    wait_done("b2b_first");
    bus.a = 16'h0010;
    bus.b = 16'h0020;
    @(posedge clk);
    #1;
    push_exp(16'h0030, 1'b0, 1'b0, 1'b0);
    chk("b2b_busy_no_gap", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    wait_done("b2b_second");

    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
